// File: rtl/c17_bist_ctrl_if.sv
// Test-control handshake between the BIST master and the c17 BIST sequencer.
// Carries run requests and the completion/result status.
interface c17_bist_ctrl_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;

  modport master (
    output start,
    output abort,
    input  busy,
    input  done,
    input  pass,
    input  signature
  );

  modport slave (
    input  start,
    input  abort,
    output busy,
    output done,
    output pass,
    output signature
  );
endinterface

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the c17 netlist: LFSR pattern source, input mux,
// MISR response compactor and golden-signature compare.
module c17_bist_ctrl #(
  parameter int unsigned N_PATTERNS = 32,
  parameter logic [4:0]  LFSR_SEED  = 5'h1F,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  c17_bist_ctrl_if.slave  ctl,
  input  logic [4:0]      func_in,
  output logic [4:0]      cut_in,
  input  logic [1:0]      cut_out
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [4:0] SEED =
    (LFSR_SEED == 5'h00) ? 5'h01 : LFSR_SEED;
  localparam logic [7:0] LAST = 8'(N_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  state_t     state;
  logic [4:0] lfsr;
  logic [7:0] misr;
  logic [7:0] cnt;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic [4:0] lfsr_nxt;
  logic [7:0] misr_nxt;

  assign lfsr_nxt = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
  assign misr_nxt = {misr[6:0], 1'b0}
                  ^ (misr[7] ? 8'h1D : 8'h00)
                  ^ {6'b0, cut_out};

  assign cut_in        = busy_q ? lfsr : func_in;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.pass      = pass_q;
  assign ctl.signature = misr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= SEED;
      misr   <= 8'h00;
      cnt    <= 8'h00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (ctl.start) begin
            state  <= RUN;
            lfsr   <= SEED;
            misr   <= 8'h00;
            cnt    <= 8'h00;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
          end
        end
        RUN: begin
          if (ctl.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            pass_q <= 1'b0;
          end else begin
            misr <= misr_nxt;
            lfsr <= lfsr_nxt;
            cnt  <= cnt + 8'd1;
            if (cnt == LAST)
              state <= CHECK;
          end
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (ctl.abort) begin
            state  <= IDLE;
            pass_q <= 1'b0;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
            pass_q <= (misr == GOLDEN_SIG);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Bench for c17_bist_ctrl: three configurations, a gate-level c17 model
// in the loop, table vectors, directed corner cases and random runs.
module tb_c17_bist_ctrl;

  localparam int NB = 32;
  localparam int NC = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [1:0] c17(input logic [4:0] x);
    logic n1, n2, n3, n6, n7;
    logic n10, n11, n16, n19;
    {n7, n6, n3, n2, n1} = x;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  // Pattern i as a window of the maximal-length bit stream b[t+5]=b[t]^b[t+2].
  function automatic logic [4:0] pat(input logic [4:0] seed, input int i);
    bit b[300];
    for (int k = 0; k < 5; k++) b[k] = seed[4-k];
    for (int k = 5; k < i + 5; k++) b[k] = b[k-5] ^ b[k-3];
    return {b[i], b[i+1], b[i+2], b[i+3], b[i+4]};
  endfunction

  // Signature after k patterns, as polynomial reduction mod 0x11D.
  function automatic int ref_sig(input logic [4:0] seed, input int k);
    int m = 0;
    for (int i = 0; i < k; i++) begin
      m = m * 2;
      if (m >= 256) m = m ^ 'h11D;
      m = m ^ int'(c17(pat(seed, i)));
    end
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  c17_bist_ctrl_if ia();
  c17_bist_ctrl_if ib();
  c17_bist_ctrl_if ic();

  logic [4:0] func_a, func_b, func_c;
  logic [4:0] cut_a, cut_b, cut_c;
  logic [1:0] out_a, out_b, out_c;
  logic       fault_a = 1'b0;

  assign out_a = fault_a ? 2'b00 : c17(cut_a);
  assign out_b = c17(cut_b);
  assign out_c = c17(cut_c);

  c17_bist_ctrl #(.N_PATTERNS(1), .LFSR_SEED(5'h1F), .GOLDEN_SIG(8'h01))
    dut_a (.clk(clk), .rst(rst), .ctl(ia),
           .func_in(func_a), .cut_in(cut_a), .cut_out(out_a));

  c17_bist_ctrl #(.N_PATTERNS(NB), .LFSR_SEED(5'h1F), .GOLDEN_SIG(8'h00))
    dut_b (.clk(clk), .rst(rst), .ctl(ib),
           .func_in(func_b), .cut_in(cut_b), .cut_out(out_b));

  c17_bist_ctrl #(.N_PATTERNS(NC), .LFSR_SEED(5'h00), .GOLDEN_SIG(8'h00))
    dut_c (.clk(clk), .rst(rst), .ctl(ic),
           .func_in(func_c), .cut_in(cut_c), .cut_out(out_c));

  typedef struct {
    logic [4:0] func;
    logic [4:0] exp_cut;
  } byp_vec_t;

  byp_vec_t   byp[6];
  logic [4:0] order[5];

  initial begin
    int k;
    int sb;
    byp[0] = '{5'h00, 5'h00};
    byp[1] = '{5'h1F, 5'h1F};
    byp[2] = '{5'h0A, 5'h0A};
    byp[3] = '{5'h15, 5'h15};
    byp[4] = '{5'h01, 5'h01};
    byp[5] = '{5'h10, 5'h10};
    order  = '{5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h11};

    {ia.start, ia.abort, ib.start, ib.abort, ic.start, ic.abort} = '0;
    func_a = '0; func_b = '0; func_c = '0;
    step();
    step();
    #1 rst = 1'b0;
    step();
    chk("rst_busy", int'(ib.busy), 0);
    chk("rst_done", int'(ib.done), 0);
    chk("rst_pass", int'(ib.pass), 0);
    chk("rst_sig", int'(ib.signature), 0);

    foreach (byp[i]) begin
      func_a = byp[i].func;
      #1 chk("bypass", int'(cut_a), int'(byp[i].exp_cut));
    end

    // One pattern against the good circuit.
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    chk("one_busy", int'(ia.busy), 1);
    chk("one_cut", int'(cut_a), 'h1F);
    step();
    chk("one_sig", int'(ia.signature), 'h01);
    chk("one_done_early", int'(ia.done), 0);
    step();
    chk("one_done", int'(ia.done), 1);
    chk("one_pass", int'(ia.pass), 1);
    chk("one_busy_off", int'(ia.busy), 0);

    // Same run with stuck-at-0 responses, restarted from DONE.
    fault_a = 1'b1;
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    chk("flt_done_clr", int'(ia.done), 0);
    step();
    step();
    chk("flt_sig", int'(ia.signature), 0);
    chk("flt_done", int'(ia.done), 1);
    chk("flt_pass", int'(ia.pass), 0);
    fault_a = 1'b0;

    // Pattern order, then full run and held-start restart.
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    foreach (order[i]) begin
      chk("order", int'(cut_b), int'(order[i]));
      step();
    end
    k = 0;
    while (ib.done !== 1'b1 && k < 100) begin
      k++;
      step();
    end
    chk("full_timeout", int'(k < 100), 1);
    sb = ref_sig(5'h1F, NB);
    chk("full_sig", int'(ib.signature), sb);
    chk("full_pass", int'(ib.pass), int'(sb == 0));
    ib.start = 1'b1;
    step();
    k = 0;
    while (ib.done !== 1'b1 && k < 100) begin
      k++;
      step();
    end
    ib.start = 1'b0;
    chk("restart_gap", k, NB + 1);
    chk("restart_sig", int'(ib.signature), sb);

    // Abort in the 10th RUN cycle.
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    repeat (9) step();
    chk("ab_busy_pre", int'(ib.busy), 1);
    ib.abort = 1'b1;
    step();
    ib.abort = 1'b0;
    chk("ab_busy", int'(ib.busy), 0);
    chk("ab_pass", int'(ib.pass), 0);
    chk("ab_sig", int'(ib.signature), ref_sig(5'h1F, 9));
    k = 0;
    repeat (40) begin
      if (ib.done === 1'b1) k++;
      step();
    end
    chk("ab_no_done", k, 0);
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    chk("ab_restart", int'(cut_b), 'h1F);
    step();
    step();

    // Reset mid-run.
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(ib.busy), 0);
    chk("mid_rst_done", int'(ib.done), 0);
    chk("mid_rst_sig", int'(ib.signature), 0);
    func_b = 5'h0A;
    #1 chk("mid_rst_cut", int'(cut_b), 'h0A);
    #1 rst = 1'b0;
    step();

    // Random runs: seed 0 substituted by 01, more than one LFSR period.
    for (int r = 0; r < 8; r++) begin
      int ab;
      bit fin;
      ab = $urandom_range(1, 60);
      repeat ($urandom_range(0, 2)) begin
        func_c = 5'($urandom);
        #1 chk("rnd_bypass", int'(cut_c), int'(func_c));
        step();
      end
      ic.start = 1'b1;
      ic.abort = ($urandom_range(0, 1) == 1);
      step();
      chk("rnd_start", int'(ic.busy), 1);
      ic.start = 1'b0;
      ic.abort = 1'b0;
      fin = 1'b0;
      for (int c = 1; c <= NC + 2 && !fin; c++) begin
        func_c = 5'($urandom);
        ic.start = (c <= NC) && ($urandom_range(0, 3) == 0);
        #1;
        if (c <= NC)
          chk("rnd_pat", int'(cut_c), int'(pat(5'h01, c - 1)));
        if (c == NC + 2) begin
          sb = ref_sig(5'h01, NC);
          chk("rnd_done", int'(ic.done), 1);
          chk("rnd_sig", int'(ic.signature), sb);
          chk("rnd_pass", int'(ic.pass), int'(sb == 0));
          fin = 1'b1;
        end else if (c == ab) begin
          ic.abort = 1'b1;
          ic.start = 1'b0;
          step();
          ic.abort = 1'b0;
          chk("rnd_ab_busy", int'(ic.busy), 0);
          chk("rnd_ab_done", int'(ic.done), 0);
          chk("rnd_ab_sig", int'(ic.signature),
              ref_sig(5'h01, (c - 1 < NC) ? c - 1 : NC));
          fin = 1'b1;
        end else begin
          step();
        end
      end
      ic.start = 1'b0;
      if (ic.done === 1'b1) begin
        sb = int'(ic.signature);
        ic.abort = 1'b1;
        step();
        ic.abort = 1'b0;
        chk("rnd_idle_abort", int'(ic.done), 1);
        chk("rnd_idle_sig", int'(ic.signature), sb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
